// File: rtl/lsu_mem_responder_pkg.sv
// Shared definitions for the LSU data-memory responder: FSM encodings,
// lane widths and the placement/size of the on-chip data memory.
package lsu_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_MASK_W = DMEM_DATA_W / 8;
  localparam int DMEM_DEPTH_LOG2 = 10;
  localparam logic [31:0] DMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] DMEM_BYTES = 32'(4) << DMEM_DEPTH_LOG2;

endpackage

// File: rtl/lsu_mem_responder_dmem_array.sv
// Single-port synchronous data storage with byte write enables.
// A write and the capture of the addressed word (old contents) happen on
// the same rising edge when en is high; rdata holds between accesses.
module ysyx_23060251_dmem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W/8-1:0]   mask,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Byte-masked write plus read-data capture, both on an enabled edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
          if (mask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Far-end responder of the LSU memory interface. Accepts one request at a
// time, waits LATENCY cycles, performs the access, then holds one response
// until the LSU takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and once raised, valid and its
// payload stay stable until that transfer edge. req_ready_o is high only
// in IDLE, so request fields are ignored at all other times.
module lsu_mem_responder
  import lsu_mem_responder_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = DMEM_DATA_W,
  parameter int                DEPTH_LOG2 = DMEM_DEPTH_LOG2,
  parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(DMEM_BASE),
  parameter int                LATENCY    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W/8-1:0] req_mask_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [1:0]          dbg_state_o
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4) << DEPTH_LOG2;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;

  logic              lat_wen;
  logic [ADDR_W-1:0] lat_addr;
  logic [MASK_W-1:0] lat_mask;
  logic [DATA_W-1:0] lat_wdata;

  logic rsp_err_q;
  logic rsp_load_q;

  // Access controls: with zero latency the access uses the live request.
  logic              access;
  logic              use_req;
  logic              acc_wen;
  logic [ADDR_W-1:0] acc_addr;
  logic [MASK_W-1:0] acc_mask;
  logic [DATA_W-1:0] acc_wdata;
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [DATA_W-1:0] arr_rdata;

  // Next-state and access decision from the current state and handshakes.
  always_comb begin
    state_next = state;
    access     = 1'b0;
    use_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 0) begin
            access     = 1'b1;
            use_req    = 1'b1;
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          access     = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign acc_wen   = use_req ? req_wen_i   : lat_wen;
  assign acc_addr  = use_req ? req_addr_i  : lat_addr;
  assign acc_mask  = use_req ? req_mask_i  : lat_mask;
  assign acc_wdata = use_req ? req_wdata_i : lat_wdata;

  // Unsigned subtraction makes addresses below BASE wrap high and fail too.
  assign offset   = acc_addr - BASE;
  assign in_range = (offset < SPAN);

  ysyx_23060251_dmem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk_i),
    .en   (access & in_range),
    .wen  (acc_wen),
    .addr (offset[DEPTH_LOG2+1:2]),
    .mask (acc_mask),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  // Control state: FSM, latency counter and response flags.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req_valid_i) begin
        cnt <= CNT_INIT;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        rsp_err_q  <= ~in_range;
        rsp_load_q <= ~acc_wen & in_range;
      end
    end
  end

  // Request capture on acceptance; payload needs no reset.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && req_valid_i) begin
      lat_wen   <= req_wen_i;
      lat_addr  <= req_addr_i;
      lat_mask  <= req_mask_i;
      lat_wdata <= req_wdata_i;
    end
  end

  assign req_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_err_o   = rsp_valid_o & rsp_err_q;
  assign rsp_rdata_o = (rsp_valid_o & rsp_load_q) ? arr_rdata : '0;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: one instance with LATENCY=2 and
// driven response backpressure, one with LATENCY=0 and rsp_ready tied high.
module tb_lsu_mem_responder;

  logic clk = 1'b0;
  logic rst_n;

  // LATENCY=2 instance
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  // LATENCY=0 instance
  logic        z_req_valid, z_req_ready, z_req_wen;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_mask;
  logic        z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
  logic [1:0]  z_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_mem_responder #(.LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_mask_i(req_mask), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .dbg_state_o(dbg_state)
  );

  lsu_mem_responder #(.LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_wen_i(z_req_wen),
    .req_addr_i(z_req_addr), .req_mask_i(z_req_mask), .req_wdata_i(z_req_wdata),
    .rsp_valid_o(z_rsp_valid), .rsp_ready_i(1'b1),
    .rsp_rdata_o(z_rsp_rdata), .rsp_err_o(z_rsp_err), .dbg_state_o(z_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance; called #1 after an edge.
  task automatic txn(input logic wen, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] wdata, input string tag,
                     output logic [31:0] rdata, output logic err, output int lat);
    int k;
    req_wen = wen; req_addr = addr; req_mask = mask; req_wdata = wdata;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    check({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, "_rsp_wait"}, 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata, input logic exp_err, input string tag);
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, addr, mask, wdata, tag, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input string tag);
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, addr, 4'h0, 32'h0, tag, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_rdata"}, rd, exp_data);
  endtask

  // LATENCY=0 vectors: two stores then two loads, back to back.
  logic        z_wen_v  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] z_addr_v [4] = '{32'h8000_0040, 32'h8000_0044, 32'h8000_0040, 32'h8000_0044};
  logic [31:0] z_data_v [4] = '{32'h0A0B_0C0D, 32'h1122_3344, 32'h0, 32'h0};
  logic [31:0] z_exp_v  [4] = '{32'h0, 32'h0, 32'h0A0B_0C0D, 32'h1122_3344};

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_mask = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_wen = 1'b0; z_req_addr = '0; z_req_mask = '0; z_req_wdata = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_z_req_ready", 32'(z_req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full-word store then load
    do_store(32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, "t1_st");
    check("t1_idle_ready", 32'(req_ready), 32'd1);
    do_load(32'h8000_0010, 32'hDEAD_BEEF, 1'b0, "t1_ld");

    // 2: partial byte stores merge into the existing word
    do_store(32'h8000_0010, 4'b0001, 32'h0000_00AA, 1'b0, "t2_st0");
    do_store(32'h8000_0010, 4'b0010, 32'h0000_BB00, 1'b0, "t2_st1");
    do_load(32'h8000_0010, 32'hDEAD_BBAA, 1'b0, "t2_ld");
    do_load(32'h8000_0013, 32'hDEAD_BBAA, 1'b0, "t2_ld_lowbits");

    // 3: response backpressure; a request pulse during RESP is ignored
    req_wen = 1'b0; req_addr = 32'h8000_0010; req_mask = 4'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(rsp_valid), 32'd1);
      check("t3_hold_rdata", rsp_rdata, 32'hDEAD_BBAA);
      check("t3_hold_err", 32'(rsp_err), 32'd0);
      check("t3_hold_ready", 32'(req_ready), 32'd0);
      if (i == 1) begin
        req_wen = 1'b1; req_mask = 4'hF; req_wdata = 32'h0; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("t3_release_ready", 32'(req_ready), 32'd1);
    check("t3_release_valid", 32'(rsp_valid), 32'd0);
    do_load(32'h8000_0010, 32'hDEAD_BBAA, 1'b0, "t3_ld");

    // 4: out-of-range accesses; the edge words they would alias stay intact
    do_store(32'h8000_0000, 4'hF, 32'h1111_1111, 1'b0, "t4_st_first");
    do_store(32'h8000_0FFC, 4'hF, 32'h2222_2222, 1'b0, "t4_st_last");
    do_load(32'h7FFF_FFFC, 32'h0, 1'b1, "t4_ld_below");
    do_load(32'h8000_1000, 32'h0, 1'b1, "t4_ld_above");
    do_store(32'h7FFF_FFFC, 4'hF, 32'hFFFF_FFFF, 1'b1, "t4_st_below");
    do_store(32'h8000_1000, 4'hF, 32'hFFFF_FFFF, 1'b1, "t4_st_above");
    do_load(32'h8000_0000, 32'h1111_1111, 1'b0, "t4_ld_first");
    do_load(32'h8000_0FFC, 32'h2222_2222, 1'b0, "t4_ld_last");

    // 5: reset during WAIT drops the pending store
    do_store(32'h8000_0020, 4'hF, 32'h1234_5678, 1'b0, "t5_st_prior");
    req_wen = 1'b1; req_addr = 32'h8000_0020; req_mask = 4'hF; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("t5_in_wait", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_still_idle", 32'(rsp_valid), 32'd0);
    do_load(32'h8000_0020, 32'h1234_5678, 1'b0, "t5_ld");

    // 6: LATENCY=0, valid held high, one transaction every two cycles
    for (int i = 0; i < 4; i++) begin
      z_req_wen = z_wen_v[i]; z_req_addr = z_addr_v[i]; z_req_mask = 4'hF;
      z_req_wdata = z_data_v[i]; z_req_valid = 1'b1;
      @(posedge clk); #1;
      check("t6_rsp_valid", 32'(z_rsp_valid), 32'd1);
      check("t6_busy", 32'(z_req_ready), 32'd0);
      check("t6_rdata", z_rsp_rdata, z_exp_v[i]);
      check("t6_err", 32'(z_rsp_err), 32'd0);
      @(posedge clk); #1;
      check("t6_idle_valid", 32'(z_rsp_valid), 32'd0);
      check("t6_idle_ready", 32'(z_req_ready), 32'd1);
    end
    z_req_valid = 1'b0;
    z_req_wen = 1'b0; z_req_addr = 32'h8000_1000; z_req_valid = 1'b1;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    check("t6_oor_err", 32'(z_rsp_err), 32'd1);
    check("t6_oor_rdata", z_rsp_rdata, 32'h0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
